// File: rtl/alu_issue_pkg.sv
// Shared constants and payload type for the RV32I ALU issue stage.
// Optional writeback forwarding is enabled by defining ALU_ISSUE_FWD_EN.
package alu_issue_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Operand source selects produced by the opcode decoder
    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    localparam logic [1:0] BSEL_RS2  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;
    localparam logic [1:0] BSEL_ZERO = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] alu_a;
        logic [XLEN-1:0] alu_b;
        logic [3:0]      alu_op;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      opcode;
        logic            illegal;
    } issue_payload_t;

endpackage

// File: rtl/alu_opdec.sv
// Combinational RV32I opcode decoder: ALU op, operand selects and illegal flag.
// Forwarding (ALU_ISSUE_FWD_EN) does not affect this block.
module alu_opdec
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  alu_op_o,
    output logic [1:0]  a_sel_o,
    output logic [1:0]  b_sel_o,
    output logic        illegal_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       unused_instr_bits;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    always_comb begin
        alu_op_o  = ALU_ADD;
        a_sel_o   = ASEL_ZERO;
        b_sel_o   = BSEL_ZERO;
        illegal_o = 1'b0;
        case (opc)
            OPC_OP: begin
                alu_op_o = {instr_i[30], f3};
                a_sel_o  = ASEL_RS1;
                b_sel_o  = BSEL_RS2;
            end
            OPC_OP_IMM: begin
                // bit 30 is immediate data except for the shift-right pair
                alu_op_o = {instr_i[30] & (f3 == 3'b101), f3};
                a_sel_o  = ASEL_RS1;
                b_sel_o  = BSEL_IMM;
            end
            OPC_LUI: begin
                b_sel_o = BSEL_IMM;
            end
            OPC_AUIPC: begin
                a_sel_o = ASEL_PC;
                b_sel_o = BSEL_IMM;
            end
            OPC_LOAD, OPC_STORE: begin
                a_sel_o = ASEL_RS1;
                b_sel_o = BSEL_IMM;
            end
            OPC_BRANCH: begin
                a_sel_o = ASEL_RS1;
                b_sel_o = BSEL_RS2;
                case (f3[2:1])
                    2'b00:   alu_op_o  = ALU_SUB;
                    2'b10:   alu_op_o  = ALU_SLT;
                    2'b11:   alu_op_o  = ALU_SLTU;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                a_sel_o = ASEL_PC;
                b_sel_o = BSEL_FOUR;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single-entry issue register between decode and the ALU with valid/ready handshakes.
// Define ALU_ISSUE_FWD_EN to add the writeback forwarding port on rs1/rs2.
module alu_issue #(
    parameter int unsigned XLEN = alu_issue_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
`ifdef ALU_ISSUE_FWD_EN
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      opcode,
    output logic            illegal
);
    import alu_issue_pkg::*;

    logic [3:0]      dec_op;
    logic [1:0]      dec_a_sel;
    logic [1:0]      dec_b_sel;
    logic            dec_illegal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            capture;
    logic            out_valid_d, out_valid_q;
    issue_payload_t  payload_d, payload_q;

    alu_opdec u_opdec (
        .instr_i   (instr),
        .alu_op_o  (dec_op),
        .a_sel_o   (dec_a_sel),
        .b_sel_o   (dec_b_sel),
        .illegal_o (dec_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    // x0 is never forwarded; it always reads as the register-file value
    always_comb begin
        rs1_val = rs1_data;
        rs2_val = rs2_data;
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[19:15])) rs1_val = fwd_data;
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[24:20])) rs2_val = fwd_data;
    end
`else
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    assign in_ready = ~out_valid_q | out_ready;
    assign capture  = in_valid & in_ready & ~flush;

    always_comb begin
        out_valid_d = out_valid_q;
        payload_d   = payload_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d          = 1'b1;
            payload_d.alu_op     = dec_op;
            payload_d.store_data = rs2_val;
            payload_d.rd         = instr[11:7];
            payload_d.funct3     = instr[14:12];
            payload_d.opcode     = instr[6:0];
            payload_d.illegal    = dec_illegal;
            case (dec_a_sel)
                ASEL_RS1: payload_d.alu_a = rs1_val;
                ASEL_PC:  payload_d.alu_a = pc;
                default:  payload_d.alu_a = '0;
            endcase
            case (dec_b_sel)
                BSEL_RS2:  payload_d.alu_b = rs2_val;
                BSEL_IMM:  payload_d.alu_b = imm;
                BSEL_FOUR: payload_d.alu_b = XLEN'(4);
                default:   payload_d.alu_b = '0;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            payload_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            payload_q   <= payload_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_a      = payload_q.alu_a;
    assign alu_b      = payload_q.alu_b;
    assign alu_op     = payload_q.alu_op;
    assign store_data = payload_q.store_data;
    assign rd         = payload_q.rd;
    assign funct3     = payload_q.funct3;
    assign opcode     = payload_q.opcode;
    assign illegal    = payload_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected payloads queued at capture, compared on output.
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, imm;
    logic        in_ready, out_valid, illegal;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [31:0] tbl[$];

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .store_data (store_data),
        .rd         (rd),
        .funct3     (funct3),
        .opcode     (opcode),
        .illegal    (illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdi, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rdi, opc};
    endfunction

    // Reference decode written straight from the ISA operand table
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] im);
        exp_t e;
        logic [2:0] f3;
        f3    = ins[14:12];
        e     = '0;
        e.rd  = ins[11:7];
        e.f3  = f3;
        e.opc = ins[6:0];
        e.sd  = r2;
        case (ins[6:0])
            7'h33: begin e.op = {ins[30], f3}; e.a = r1; e.b = r2; end
            7'h13: begin e.op = {(f3 == 3'b101) ? ins[30] : 1'b0, f3}; e.a = r1; e.b = im; end
            7'h37: e.b = im;
            7'h17: begin e.a = p; e.b = im; end
            7'h03, 7'h23: begin e.a = r1; e.b = im; end
            7'h63: begin
                e.a = r1;
                e.b = r2;
                if (f3 == 3'b000 || f3 == 3'b001)      e.op = 4'b1000;
                else if (f3 == 3'b100 || f3 == 3'b101) e.op = 4'b0010;
                else if (f3 == 3'b110 || f3 == 3'b111) e.op = 4'b0011;
                else                                   e.ill = 1'b1;
            end
            7'h6F, 7'h67: begin e.a = p; e.b = 32'd4; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: check at negedge+1, update scoreboard, advance to the next negedge
    task automatic cycle();
        exp_t        e;
        logic        ready;
        logic [31:0] r1, r2;
        #1;
        ready = (sb.size() == 0) || out_ready;
        if (rst_n) begin
            check_eq("in_ready", 32'(in_ready), 32'(ready));
            check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                e = sb[0];
                check_eq("alu_a", alu_a, e.a);
                check_eq("alu_b", alu_b, e.b);
                check_eq("alu_op", 32'(alu_op), 32'(e.op));
                check_eq("store_data", store_data, e.sd);
                check_eq("rd", 32'(rd), 32'(e.rd));
                check_eq("funct3", 32'(funct3), 32'(e.f3));
                check_eq("opcode", 32'(opcode), 32'(e.opc));
                check_eq("illegal", 32'(illegal), 32'(e.ill));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (!rst_n || flush) sb.delete();
        if (rst_n && !flush && in_valid && ready) begin
            r1 = rs1_data;
            r2 = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
            if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[19:15]) r1 = fwd_data;
            if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[24:20]) r2 = fwd_data;
`endif
            sb.push_back(model(instr, pc, r1, r2, imm));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        instr     = ins;
        pc        = $urandom;
        rs1_data  = r1;
        rs2_data  = r2;
        imm       = im;
        out_ready = ordy;
        flush     = fl;
        cycle();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_alu_a"}, alu_a, 32'd0);
        check_eq({tag, "_alu_b"}, alu_b, 32'd0);
        check_eq({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check_eq({tag, "_store_data"}, store_data, 32'd0);
        check_eq({tag, "_rd"}, 32'(rd), 32'd0);
        check_eq({tag, "_funct3"}, 32'(funct3), 32'd0);
        check_eq({tag, "_opcode"}, 32'(opcode), 32'd0);
        check_eq({tag, "_illegal"}, 32'(illegal), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
        tbl.push_back(32'h002081B3);                              // ADD x3,x1,x2
        tbl.push_back(32'h40208233);                              // SUB
        tbl.push_back(32'h40415093);                              // SRAI x1,x2,4
        tbl.push_back(32'hC0000293);                              // ADDI x5,x0,-1024
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b100, 5'd6, 7'h33)); // XOR
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd6, 7'h33)); // SLL
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b101, 5'd6, 7'h33)); // SRL
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd6, 7'h33)); // SLTU
        tbl.push_back(enc(7'h20, 5'd1, 5'd2, 3'b001, 5'd9, 7'h13)); // SLLI with bit30 set
        tbl.push_back(enc(7'h00, 5'd3, 5'd2, 3'b101, 5'd9, 7'h13)); // SRLI
        tbl.push_back(enc(7'h09, 5'd5, 5'd3, 3'b100, 5'd7, 7'h37)); // LUI
        tbl.push_back(enc(7'h01, 5'd0, 5'd0, 3'b000, 5'd8, 7'h17)); // AUIPC
        tbl.push_back(enc(7'h00, 5'd4, 5'd1, 3'b010, 5'd5, 7'h03)); // LW
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd8, 7'h23)); // SW
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd8, 7'h63)); // BEQ
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b101, 5'd8, 7'h63)); // BGE
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd8, 7'h63)); // BLTU
        tbl.push_back(enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd8, 7'h63)); // branch f3=010
        tbl.push_back(enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, 7'h6F)); // JAL
        tbl.push_back(enc(7'h00, 5'd0, 5'd1, 3'b000, 5'd1, 7'h67)); // JALR
        tbl.push_back(32'h0000007F);                              // unknown opcode
        tbl.push_back(32'h0000000F);                              // FENCE, not handled

        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        check_reset_vals("reset");

        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 32'h40415093, 32'd100, 32'd0, 32'd4, 1'b1, 1'b0);
        drive(1'b1, 32'hC0000293, 32'd1, 32'd2, 32'hFFFF_FC00, 1'b1, 1'b0);
        foreach (tbl[i]) drive(1'b1, tbl[i], $urandom, $urandom, $urandom, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Back-pressure: held SUB, new instr offered meanwhile, then accepted with no bubble
        drive(1'b1, 32'h40208233, 32'd9, 32'd3, 32'd0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, tbl[4], 32'h11, 32'h22, 32'd0, 1'b0, 1'b0);
        drive(1'b1, tbl[4], 32'h11, 32'h22, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush drops the held instruction and the one on offer
        drive(1'b1, tbl[16], 32'd4, 32'd8, 32'd0, 1'b0, 1'b0);
        drive(1'b1, tbl[0], 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset in the middle of a stall
        drive(1'b1, tbl[13], 32'hAAAA, 32'h5555, 32'h10, 1'b0, 1'b0);
        drive(1'b1, tbl[1], 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, tbl[1], 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        check_reset_vals("midstall_reset");

`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'h0000_DEAD;
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
        fwd_rd = 5'd0; fwd_data = 32'h0000_BEEF;
        drive(1'b1, enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd3, 7'h33), 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
        fwd_rd = 5'd2;
        drive(1'b1, tbl[13], 32'd40, 32'd50, 32'd12, 1'b1, 1'b0);
        fwd_valid = 1'b0;
`endif

        // Randomised traffic with back-pressure and occasional flush
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            ins = tbl[$urandom_range(0, tbl.size() - 1)];
            ins[11:7] = 5'($urandom);
`ifdef ALU_ISSUE_FWD_EN
            fwd_valid = 1'($urandom);
            fwd_rd    = 5'($urandom_range(0, 3));
            fwd_data  = $urandom;
`endif
            drive(($urandom_range(0, 3) != 0), ins, $urandom, $urandom, $urandom,
                  1'($urandom), ($urandom_range(0, 15) == 0));
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
